// File: rtl/arbiter_pkg.sv
// Shared types for the bank-to-arbiter request path: field widths, the
// request payload carried by each bank source, and the burst FSM states.
package arbiter_pkg;

    localparam int unsigned INDEX_BITS = 7;
    localparam int unsigned RA_BITS    = 16;
    localparam int unsigned CA_BITS    = 10;
    localparam int unsigned DATA_BITS  = 16;
    localparam int unsigned BA_BITS    = 2;
    localparam int unsigned BG_BITS    = 2;

    typedef struct packed {
        logic [DATA_BITS-1:0]  data;
        logic [INDEX_BITS-1:0] idx;
        logic [RA_BITS-1:0]    row;
        logic [CA_BITS-1:0]    col;
    } bank_req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } src_state_t;

endpackage

// File: rtl/bank_req_fifo.sv
// Synchronous first-word-fall-through FIFO of bank requests.
// Ports: clk, rst (async, active-high), push/wr_data in, pop in,
//        rd_data (head entry, always visible), full, empty, count.
// Reset clears the storage so the head reads as zero.
module bank_req_fifo
    import arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  bank_req_t                  wr_data,
    input  logic                       pop,
    output bank_req_t                  rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    bank_req_t        mem_q [DEPTH];
    bank_req_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == CNT_W'(0));
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointer/count update; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bank_burst_source.sv
// Per-bank request source toward the arbiter. Buffers scheduler requests in
// a FWFT FIFO and offers them in bursts of up to MAX_BURST grants, dropping
// valid for GAP_CYCLES between bursts so the arbiter can rotate banks.
// Ports: clk, rst (async, active-high);
//        scheduler side: in_valid/in_ready, in_data, in_idx, in_row, in_col;
//        arbiter side:   valid/Ready, data_o, idx_o, row_o, col_o; occupancy.
// Optional: define BANK_SRC_ROW_BREAK_EN to also end a burst when the head
// entry's row differs from the row latched at burst start.
module bank_burst_source
    import arbiter_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned MAX_BURST  = 4,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_BITS-1:0]       in_data,
    input  logic [INDEX_BITS-1:0]      in_idx,
    input  logic [RA_BITS-1:0]         in_row,
    input  logic [CA_BITS-1:0]         in_col,
    output logic                       valid,
    input  logic                       Ready,
    output logic [DATA_BITS-1:0]       data_o,
    output logic [INDEX_BITS-1:0]      idx_o,
    output logic [RA_BITS-1:0]         row_o,
    output logic [CA_BITS-1:0]         col_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned OCC_W = $clog2(DEPTH+1);
    localparam int unsigned BC_W  = $clog2(MAX_BURST+1);
    localparam int unsigned GC_W  = $clog2(GAP_CYCLES+1);

    src_state_t       state_q, state_d;
    logic [BC_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [GC_W-1:0]  gap_cnt_q, gap_cnt_d;
`ifdef BANK_SRC_ROW_BREAK_EN
    logic [RA_BITS-1:0] burst_row_q, burst_row_d;
`endif

    bank_req_t        wr_req, head;
    logic             full, empty, push, pop, row_ok, last_pop;
    logic [OCC_W-1:0] count;

    assign wr_req = '{data: in_data, idx: in_idx, row: in_row, col: in_col};
    assign push   = in_valid & ~full;

    bank_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (wr_req),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

`ifdef BANK_SRC_ROW_BREAK_EN
    assign row_ok = (head.row == burst_row_q);
`else
    assign row_ok = 1'b1;
`endif

    // valid depends only on registered state, never on Ready.
    assign valid = (state_q == BURST) & ~empty &
                   (burst_cnt_q < BC_W'(MAX_BURST)) & row_ok;
    assign pop   = valid & Ready;
    // Popping the last stored entry closes the burst even if a push lands in
    // the same cycle; the newcomer waits for a fresh burst.
    assign last_pop = pop & (count == OCC_W'(1));

    assign in_ready  = ~full;
    assign occupancy = count;
    assign data_o    = head.data;
    assign idx_o     = head.idx;
    assign row_o     = head.row;
    assign col_o     = head.col;

    // Burst FSM: next state and counters.
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        gap_cnt_d   = gap_cnt_q;
`ifdef BANK_SRC_ROW_BREAK_EN
        burst_row_d = burst_row_q;
`endif
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d     = BURST;
                    burst_cnt_d = '0;
`ifdef BANK_SRC_ROW_BREAK_EN
                    burst_row_d = head.row;
`endif
                end
            end
            BURST: begin
                if (pop) begin
                    burst_cnt_d = burst_cnt_q + BC_W'(1);
                end
                if (empty || !row_ok || last_pop ||
                    (pop && (burst_cnt_q + BC_W'(1) == BC_W'(MAX_BURST))) ||
                    (burst_cnt_q >= BC_W'(MAX_BURST))) begin
                    state_d   = GAP;
                    gap_cnt_d = '0;
                end
            end
            GAP: begin
                if (gap_cnt_q == GC_W'(GAP_CYCLES - 1)) begin
                    state_d   = IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
            gap_cnt_q   <= '0;
`ifdef BANK_SRC_ROW_BREAK_EN
            burst_row_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
`ifdef BANK_SRC_ROW_BREAK_EN
            burst_row_q <= burst_row_d;
`endif
        end
    end

endmodule
